// File: rtl/alu_op_driver.sv
// alu_op_driver: initiator-side sequencer for the combinational alu.
// Requests are buffered in a small FIFO, popped one at a time into registered
// operand outputs, and the alu result is captured into a response register
// presented over a valid/ready interface.
// Optional feature macro: ALU_OP_DRIVER_ZERO_CHK_EN (sticky zero-flag check).
module alu_op_driver #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_in1,
    input  logic [WIDTH-1:0]  req_in2,
    input  logic [CTRL_W-1:0] req_ctrl,
    output logic [WIDTH-1:0]  alu_in1,
    output logic [WIDTH-1:0]  alu_in2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_rslt,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rslt,
    output logic              rsp_zero,
    output logic              busy,
    output logic [15:0]       op_count,
    output logic              zero_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]  fifo_in1  [DEPTH];
    logic [WIDTH-1:0]  fifo_in2  [DEPTH];
    logic [CTRL_W-1:0] fifo_ctrl [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic fifo_empty;
    logic push;
    logic pop;
    logic capture;
    logic complete;

    // DEPTH is a power of two, so the count's top bit alone marks "full".
    assign fifo_empty = (count == '0);
    assign req_ready  = ~count[AW];
    assign push       = req_valid && req_ready;
    assign busy       = (state != IDLE) || !fifo_empty;

    // FIFO payload storage; only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_in1[wr_ptr]  <= req_in1;
            fifo_in2[wr_ptr]  <= req_in2;
            fifo_ctrl[wr_ptr] <= req_ctrl;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes; pops only look at the registered count.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    complete = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = DRIVE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand registers feeding the alu; they keep their last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_ctrl <= '0;
        end else if (pop) begin
            alu_in1  <= fifo_in1[rd_ptr];
            alu_in2  <= fifo_in2[rd_ptr];
            alu_ctrl <= fifo_ctrl[rd_ptr];
        end
    end

    // Response register: captured after the settle cycle, released on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rslt  <= '0;
            rsp_zero  <= 1'b0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_rslt  <= alu_rslt;
            rsp_zero  <= alu_zero;
        end else if (complete) begin
            rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (complete) begin
            op_count <= op_count + 16'd1;
        end
    end

`ifdef ALU_OP_DRIVER_ZERO_CHK_EN
    // Sticky flag raised when the alu's zero output disagrees with its own result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_err <= 1'b0;
        end else if (capture && (alu_zero != (alu_rslt == '0))) begin
            zero_err <= 1'b1;
        end
    end
`else
    assign zero_err = 1'b0;
`endif

endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
Initiator-side sequencer for the combinational `alu` (ports in1/in2/alu_ctrl -> rslt/zero).
- Accepts operation requests over a valid/ready interface and buffers them in a small FIFO.
- Drives registered, stable operands into the ALU, then captures rslt/zero into a response register.
- Presents the result over a valid/ready response interface.
- Sits between instruction-issue logic and the `alu` instance; replaces direct combinational operand drive.

Parameters:
- WIDTH, 32, operand/result width; matches `alu` data ports.
- CTRL_W, 4, alu_ctrl width.
- DEPTH, 2, request FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request FIFO can accept.
- req_in1  in  WIDTH  operand A.
- req_in2  in  WIDTH  operand B.
- req_ctrl  in  CTRL_W  ALU opcode, passed through unmodified.
- alu_in1  out  WIDTH  to alu.in1, registered.
- alu_in2  out  WIDTH  to alu.in2, registered.
- alu_ctrl  out  CTRL_W  to alu.alu_ctrl, registered.
- alu_rslt  in  WIDTH  from alu.rslt.
- alu_zero  in  1  from alu.zero.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_rslt  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- op_count  out  16  completed responses, wraps.
- zero_err  out  1  sticky zero-flag mismatch (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; FSM = IDLE. Consequently req_ready = 1 on the first cycle after release.
- Reset mid-operation: FIFO contents, operands, and response are discarded; no response is produced.
- Request handshake:
  - Push when req_valid && req_ready.
  - req_ready = !full, from registered count only.
  - A push and a pop in the same cycle are legal when not full; count is unchanged.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: if FIFO non-empty -> pop head into alu_in1/alu_in2/alu_ctrl, go to DRIVE.
  - DRIVE: one settle cycle; at the clock edge, capture alu_rslt/alu_zero into rsp_rslt/rsp_zero, set rsp_valid = 1, go to RESP.
  - RESP: hold rsp_* and alu_* stable while rsp_valid && !rsp_ready. On handshake:
    - clear rsp_valid and increment op_count (wraps 16'hFFFF -> 0);
    - if FIFO non-empty, pop the next request into alu_* on the same edge and go to DRIVE;
    - else go to IDLE.
- alu_* outputs retain their last values in IDLE; they are not cleared.
- Latency: request pushed at edge N -> operands driven after edge N+1 -> rsp_valid high after edge N+2. The next response can follow at the earliest 2 cycles after a response handshake.
- Sustained throughput: 1 op / 2 cycles with rsp_ready held high.
- The opcode is opaque to this block; no width extension; result is WIDTH bits exactly as returned.

Optional Feature:
- Macro: ALU_OP_DRIVER_ZERO_CHK_EN.
- Defined: at DRIVE capture, zero_err is set if alu_zero != (alu_rslt == 0). zero_err is sticky until reset.
- Undefined: zero_err is tied to 0 and no comparison logic is built.

Test Plan:
- Reset held low 3 cycles, released -> all outputs 0, req_ready = 1, busy = 0.
- Single req in1 = 1, in2 = 2, ctrl = 4'b0000 (add), rsp_ready = 1 -> rsp_valid 2 cycles after push, rsp_rslt = 3, rsp_zero = 0, op_count = 1.
- ctrl = 4'b0000, in1 = 0, in2 = 0 -> rsp_rslt = 0, rsp_zero = 1. With macro defined, zero_err stays 0. Force alu_zero = 0 in the bench -> zero_err = 1 and remains set.
- Push 3 back-to-back requests (DEPTH = 2) with rsp_ready = 0 -> req_ready drops once the FIFO is full. The first response is held stable 5 cycles. After releasing rsp_ready, responses arrive in order, 2 cycles apart.
- Assert rst_n low during DRIVE -> rsp_valid stays 0, FIFO empty, op_count = 0 after release.
- Preload op_count to 16'hFFFF via 65535 ops (or hierarchical force), complete one more -> op_count = 0.
